sdram_req_arbiter: RTL and testbench
====================================

# sdram_req_arbiter

Sequencer that shares the single toggle-handshake SDRAM port between the main CPU ROM fetch, the sound CPU ROM fetch, the 32-bit sprite graphics fetch and the ROM download writer. It sits between the game core and the SDRAM controller in the arcade top level. It turns address changes on each read client into SDRAM read transactions and holds each client's last fetched data. Download byte writes always win arbitration.

## Interface
- AW, 23: SDRAM word-address width
- CPU2_BASE, 23'h007000: word base of sound ROM
- SP_BASE, 23'h009000: word base of sprite ROM

Ports:
- clk_sys  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high
- dl_wr  in  1  download byte strobe, level; a 0→1 edge is one byte
- dl_addr  in  25  download byte address
- dl_data  in  8  download byte
- cpu1_addr  in  16  main CPU word address, relative to 0
- cpu1_q  out  16  last main CPU word
- cpu2_addr  in  16  sound CPU word address, relative to CPU2_BASE
- cpu2_q  out  16  last sound CPU word
- sp_addr  in  15  sprite 32-bit word address
- sp_q  out  32  last sprite longword
- mem_req  out  1  request toggle
- mem_ack  in  1  ack toggle; transaction done when mem_ack == mem_req
- mem_we  out  1  1 = write
- mem_a  out  AW  word address
- mem_ds  out  2  byte enables {hi, lo}
- mem_d  out  16  write data
- mem_q  in  16  read data, valid when ack matches
- dl_overflow  out  1  sticky: byte dropped because the write buffer was full

## Operation
- Write buffer: 1 entry. A dl_wr rising edge loads {dl_addr[23:1], dl_addr[0], dl_data} and sets wb_full. If an edge arrives while wb_full=1, the byte is dropped and dl_overflow is set until reset.
- Write transaction fields: mem_we=1, mem_a=dl_addr[23:1], mem_ds={a0,~a0}, mem_d={data,data}.
- Completing a write clears the valid bits of all three read caches.
- Read clients: each holds a latched address and a valid bit.
  - A client is pending when its valid bit is 0 or its input address differs from its latched address.
  - cpu1 mem_a = {7'b0, cpu1_addr}.
  - cpu2 mem_a = CPU2_BASE + cpu2_addr.
  - sp mem_a = SP_BASE + {sp_addr, h}. It takes two reads: h=0 gives sp_q[15:0], h=1 gives sp_q[31:16]. sp_q updates atomically after h=1 completes. Both reads use the same latched sp_addr.
  - All reads: mem_ds=2'b11, mem_we=0.
- Arbitration is evaluated in IDLE only:
  - A write (wb_full) is served first.
  - Otherwise round-robin in order cpu1→cpu2→sp. The search starts after the last granted read client.
  - The sp pair is never interleaved with other clients. A write that arrives mid-pair waits until the pair finishes.
- States:
  - IDLE: on grant, latch address/fields and toggle mem_req → WAIT.
  - WAIT: when mem_ack==mem_req, capture data into the client register (or sp low half), set valid, clear wb_full for a write. Next state is SP_HI if the sp low half just completed, else IDLE.
  - SP_HI: toggle mem_req for h=1 → WAIT.
- Address change during flight: the completed data is still stored with the old latched address. The client is then pending again and is refetched.
- Reset:
  - State→IDLE; mem_req ← mem_ack (resynchronises any in-flight transaction).
  - mem_we=0, mem_a=0, mem_ds=0, mem_d=0.
  - cpu1_q=0, cpu2_q=0, sp_q=0.
  - All valid bits=0, wb_full=0, dl_overflow=0, round-robin pointer = sp (so cpu1 is served first).

## Timing
- mem_* outputs are registered. They are stable from the mem_req toggle until the matching ack.
- Grant to toggle: 1 cycle (the IDLE cycle registers the toggle).
- Read latency from IDLE-cycle grant to q update: 1 + controller latency + 1 cycles. q is valid the cycle after the matching ack is sampled.
- Minimum gap between transactions: 1 IDLE cycle. SP_HI toggles directly, so there is no IDLE cycle between the two sprite halves.
- A write edge and a buffer-clear in the same cycle: the clear wins first, then the load. No overflow.

## Structure
- Shared package mcr3_mem_pkg holds:
  - The client enum {CL_CPU1, CL_CPU2, CL_SP, CL_DL}.
  - The state enum {IDLE, WAIT, SP_HI}.
  - The CPU2_BASE/SP_BASE defaults.
- One natural sub-module: rr_pick3, the combinational round-robin selector over three pending bits plus the last-grant pointer.

## Test plan
- After reset, cpu1_addr=16'h0010, mem_q=16'hA55A, model ack latency 4 cycles → one read at mem_a=23'h000010, cpu1_q=16'hA55A. No further requests while the address is held.
- cpu1, cpu2 and sp all change in the same cycle:
  - Grant order is cpu1, cpu2, sp-lo, sp-hi.
  - sp_addr=15'h0001 uses mem_a=23'h009002 then 23'h009003.
  - sp_q={hi,lo}, updated once.
- A dl_wr edge with dl_addr=25'h000003, dl_data=8'h5C while cpu2 is pending:
  - The write goes first with mem_a=1, mem_ds=2'b10, mem_d=16'h5C5C.
  - Caches are invalidated and then refetched.
- Two dl_wr edges 2 cycles apart with ack latency 6: the second byte is dropped and dl_overflow=1 stays high until reset.
- Reset asserted while WAIT with mem_req=1 and mem_ack=0, then ack toggles to 1 after reset:
  - mem_req resyncs to the ack value.
  - The first post-reset read completes correctly.
  - No stale data is written to any q.
- cpu1_addr changes during WAIT → old data is stored, then an immediate refetch of the new address.

Source files
------------

// File: rtl/mcr3_mem_pkg.sv
// Shared types and default ROM bases for the MCR3 SDRAM request path.
package mcr3_mem_pkg;

  typedef enum logic [1:0] {CL_CPU1, CL_CPU2, CL_SP, CL_DL} client_t;

  typedef enum logic [1:0] {IDLE, WAIT, SP_HI} state_t;

  localparam logic [22:0] CPU2_BASE_DEF = 23'h007000;
  localparam logic [22:0] SP_BASE_DEF   = 23'h009000;

  // Byte enables {hi, lo} for a byte write at the given byte-address LSB.
  function automatic logic [1:0] byte_ds(input logic a0);
    return {a0, ~a0};
  endfunction

endpackage

// File: rtl/sdram_req_arbiter_rr_pick3.sv
// Combinational round-robin selector over the three read clients.
module rr_pick3
  import mcr3_mem_pkg::*;
(
  input  logic [2:0] pend,
  input  client_t    last,
  output logic       gnt_vld,
  output client_t    gnt
);

  // Search starts at the client after the last grant and wraps around.
  always_comb begin
    gnt_vld = |pend;
    gnt     = CL_CPU1;
    case (last)
      CL_CPU1: begin
        if (pend[1])      gnt = CL_CPU2;
        else if (pend[2]) gnt = CL_SP;
        else              gnt = CL_CPU1;
      end
      CL_CPU2: begin
        if (pend[2])      gnt = CL_SP;
        else if (pend[0]) gnt = CL_CPU1;
        else              gnt = CL_CPU2;
      end
      default: begin
        if (pend[0])      gnt = CL_CPU1;
        else if (pend[1]) gnt = CL_CPU2;
        else              gnt = CL_SP;
      end
    endcase
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares the toggle-handshake SDRAM port between ROM download writes and
// three cached read clients (main CPU, sound CPU, 32-bit sprite fetch).
module sdram_req_arbiter
  import mcr3_mem_pkg::*;
#(
  parameter int            AW        = 23,
  parameter logic [AW-1:0] CPU2_BASE = AW'(CPU2_BASE_DEF),
  parameter logic [AW-1:0] SP_BASE   = AW'(SP_BASE_DEF)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic [15:0]   cpu1_addr,
  output logic [15:0]   cpu1_q,
  input  logic [15:0]   cpu2_addr,
  output logic [15:0]   cpu2_q,
  input  logic [14:0]   sp_addr,
  output logic [31:0]   sp_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic [15:0]   mem_q,
  output logic          dl_overflow
);

  state_t      state, state_nxt;
  client_t     cur, rr_last, gnt;
  logic        gnt_vld;
  logic        sp_h;

  logic        dl_wr_d, dl_rise;
  logic        wb_full, wb_a0, wb_load, wb_clr, wb_drop;
  logic [22:0] wb_a;
  logic [7:0]  wb_data;

  logic [15:0] lat1, lat2, sp_lo;
  logic [14:0] latsp;
  logic        v1, v2, vsp;
  logic        p1, p2, psp;

  logic        grant_wr, grant_rd, hi_go, done;

  logic        unused_dl;
  assign unused_dl = dl_addr[24];

  assign p1  = !v1  || (cpu1_addr != lat1);
  assign p2  = !v2  || (cpu2_addr != lat2);
  assign psp = !vsp || (sp_addr   != latsp);

  rr_pick3 u_rr (
    .pend    ({psp, p2, p1}),
    .last    (rr_last),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  // A buffer clear in the same cycle as a new edge frees the slot first.
  assign dl_rise = dl_wr && !dl_wr_d;
  assign wb_clr  = done && (cur == CL_DL);
  assign wb_load = dl_rise && (!wb_full || wb_clr);
  assign wb_drop = dl_rise && wb_full && !wb_clr;

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    hi_go     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (wb_full) begin
          grant_wr  = 1'b1;
          state_nxt = WAIT;
        end else if (gnt_vld) begin
          grant_rd  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack == mem_req) begin
          done      = 1'b1;
          state_nxt = (cur == CL_SP && !sp_h) ? SP_HI : IDLE;
        end
      end
      SP_HI: begin
        hi_go     = 1'b1;
        state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue stage: registered request fields, cache registers and flags.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_req     <= mem_ack;
      mem_we      <= 1'b0;
      mem_a       <= '0;
      mem_ds      <= '0;
      mem_d       <= '0;
      cpu1_q      <= '0;
      cpu2_q      <= '0;
      sp_q        <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      vsp         <= 1'b0;
      wb_full     <= 1'b0;
      dl_overflow <= 1'b0;
      rr_last     <= CL_SP;
      cur         <= CL_CPU1;
      sp_h        <= 1'b0;
    end else begin
      if (grant_wr) begin
        mem_req <= ~mem_req;
        cur     <= CL_DL;
        mem_we  <= 1'b1;
        mem_a   <= AW'(wb_a);
        mem_ds  <= byte_ds(wb_a0);
        mem_d   <= {wb_data, wb_data};
      end else if (grant_rd) begin
        mem_req <= ~mem_req;
        cur     <= gnt;
        rr_last <= gnt;
        mem_we  <= 1'b0;
        mem_ds  <= 2'b11;
        sp_h    <= 1'b0;
        case (gnt)
          CL_CPU1: mem_a <= AW'(cpu1_addr);
          CL_CPU2: mem_a <= CPU2_BASE + AW'(cpu2_addr);
          default: mem_a <= SP_BASE + AW'({sp_addr, 1'b0});
        endcase
      end else if (hi_go) begin
        mem_req <= ~mem_req;
        sp_h    <= 1'b1;
        mem_a   <= SP_BASE + AW'({latsp, 1'b1});
      end

      if (done) begin
        case (cur)
          CL_CPU1: begin
            cpu1_q <= mem_q;
            v1     <= 1'b1;
          end
          CL_CPU2: begin
            cpu2_q <= mem_q;
            v2     <= 1'b1;
          end
          CL_SP: begin
            if (sp_h) begin
              sp_q <= {mem_q, sp_lo};
              vsp  <= 1'b1;
            end
          end
          default: begin
            // Downloaded bytes may overwrite cached ROM words.
            v1  <= 1'b0;
            v2  <= 1'b0;
            vsp <= 1'b0;
          end
        endcase
      end

      if (wb_load)     wb_full <= 1'b1;
      else if (wb_clr) wb_full <= 1'b0;
      if (wb_drop)     dl_overflow <= 1'b1;
    end
  end

  // Capture stage: data-only registers, meaningful only under their flags.
  always_ff @(posedge clk_sys) begin
    dl_wr_d <= dl_wr;
    if (wb_load) begin
      wb_a    <= dl_addr[23:1];
      wb_a0   <= dl_addr[0];
      wb_data <= dl_data;
    end
    if (grant_rd) begin
      case (gnt)
        CL_CPU1: lat1  <= cpu1_addr;
        CL_CPU2: lat2  <= cpu2_addr;
        default: latsp <= sp_addr;
      endcase
    end
    if (done && cur == CL_SP && !sp_h) sp_lo <= mem_q;
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench: stimulus queues expected SDRAM transactions and cache
// updates; monitors pop and compare as the DUT presents them.
module tb_sdram_req_arbiter;
  import mcr3_mem_pkg::*;

  typedef struct packed {
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } txn_t;

  typedef struct packed {
    client_t     cl;
    logic [31:0] val;
  } qexp_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [15:0] cpu1_addr, cpu2_addr;
  logic [14:0] sp_addr;
  logic [15:0] cpu1_q, cpu2_q;
  logic [31:0] sp_q;
  logic        mem_req, mem_we, dl_overflow;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_q = 16'h0;
  logic [22:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;

  txn_t  exp_txn[$];
  qexp_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    lat = 4;

  sdram_req_arbiter dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .cpu1_addr   (cpu1_addr),
    .cpu1_q      (cpu1_q),
    .cpu2_addr   (cpu2_addr),
    .cpu2_q      (cpu2_q),
    .sp_addr     (sp_addr),
    .sp_q        (sp_q),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_ds      (mem_ds),
    .mem_d       (mem_d),
    .mem_q       (mem_q),
    .dl_overflow (dl_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] rom(input logic [22:0] a);
    return a[15:0] ^ 16'hA54A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM controller model; it keeps running through DUT reset.
  logic        busy = 1'b0;
  logic        tgt = 1'b0;
  int          cnt = 0;
  logic [22:0] cap_a = '0;
  always @(posedge clk_sys) begin
    if (busy) begin
      if (cnt == 0) begin
        mem_ack <= tgt;
        mem_q   <= rom(cap_a);
        busy    <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!reset && mem_req != mem_ack) begin
      busy  <= 1'b1;
      cnt   <= lat - 1;
      tgt   <= mem_req;
      cap_a <= mem_a;
    end
  end

  logic req_prev = 1'b0;
  always @(negedge clk_sys) begin : txn_mon
    txn_t t;
    if (!reset && mem_req !== req_prev) begin
      if (exp_txn.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL txn_extra: got we=%b a=%h expected no request", mem_we, mem_a);
      end else begin
        t = exp_txn.pop_front();
        chk("txn_we", 32'(mem_we), 32'(t.we));
        chk("txn_a",  32'(mem_a),  32'(t.a));
        chk("txn_ds", 32'(mem_ds), 32'(t.ds));
        if (t.we) chk("txn_d", 32'(mem_d), 32'(t.d));
      end
    end
    req_prev <= mem_req;
  end

  task automatic q_seen(input client_t cl, input logic [31:0] v);
    qexp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL q_extra: client %0d got %h expected no update", cl, v);
    end else begin
      e = exp_q.pop_front();
      chk("q_client", 32'(cl), 32'(e.cl));
      chk("q_value", v, e.val);
    end
  endtask

  logic [15:0] c1_prev = '0, c2_prev = '0;
  logic [31:0] sp_prev = '0;
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (cpu1_q !== c1_prev) q_seen(CL_CPU1, {16'h0, cpu1_q});
      if (cpu2_q !== c2_prev) q_seen(CL_CPU2, {16'h0, cpu2_q});
      if (sp_q   !== sp_prev) q_seen(CL_SP, sp_q);
    end
    c1_prev <= cpu1_q;
    c2_prev <= cpu2_q;
    sp_prev <= sp_q;
  end

  task automatic push_rd(input logic [22:0] a);
    exp_txn.push_back('{we: 1'b0, a: a, ds: 2'b11, d: 16'h0});
  endtask

  task automatic push_wr(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    exp_txn.push_back('{we: 1'b1, a: a, ds: ds, d: d});
  endtask

  task automatic push_q(input client_t cl, input logic [31:0] v);
    exp_q.push_back('{cl: cl, val: v});
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (exp_txn.size() == 0 && exp_q.size() == 0 && !busy && mem_req === mem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (8) @(negedge clk_sys);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d txns and %0d updates outstanding expected 0",
               name, exp_txn.size(), exp_q.size());
    end
  endtask

  task automatic wait_toggle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (mem_req !== mem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_no_request: got req=%b ack=%b expected a pending request", name, mem_req, mem_ack);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    cpu1_addr = 16'h0010;
    cpu2_addr = 16'h0000;
    sp_addr   = 15'h0000;
    lat       = 4;
    repeat (3) @(negedge clk_sys);
    chk("rst_cpu1_q", 32'(cpu1_q), 32'h0);
    chk("rst_cpu2_q", 32'(cpu2_q), 32'h0);
    chk("rst_sp_q", sp_q, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_ds", 32'(mem_ds), 32'h0);
    chk("rst_mem_d", 32'(mem_d), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_overflow", 32'(dl_overflow), 32'h0);

    // Cold start: every client is invalid, cpu1 goes first.
    push_rd(23'h000010); push_rd(23'h007000); push_rd(23'h009000); push_rd(23'h009001);
    push_q(CL_CPU1, 32'h0000A55A);
    push_q(CL_CPU2, 32'h0000D54A);
    push_q(CL_SP,   32'h354B354A);
    reset = 1'b0;
    wait_idle("t1");

    // All three read clients change together.
    push_rd(23'h000020); push_rd(23'h007005); push_rd(23'h009002); push_rd(23'h009003);
    push_q(CL_CPU1, 32'h0000A56A);
    push_q(CL_CPU2, 32'h0000D54F);
    push_q(CL_SP,   32'h35493548);
    cpu1_addr = 16'h0020;
    cpu2_addr = 16'h0005;
    sp_addr   = 15'h0001;
    wait_idle("t2");

    // Download write beats a pending cpu2 read; all caches are refetched.
    push_wr(23'h000001, 2'b10, 16'h5C5C);
    push_rd(23'h000020); push_rd(23'h007006); push_rd(23'h009002); push_rd(23'h009003);
    push_q(CL_CPU2, 32'h0000D54C);
    dl_addr = 25'h0000003;
    dl_data = 8'h5C;
    dl_wr   = 1'b1;
    @(negedge clk_sys);
    cpu2_addr = 16'h0006;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    wait_idle("t3");
    chk("t3_overflow", 32'(dl_overflow), 32'h0);

    // Second byte arrives while the first is still in flight.
    lat = 6;
    push_wr(23'h000008, 2'b01, 16'h1111);
    push_rd(23'h000020); push_rd(23'h007006); push_rd(23'h009002); push_rd(23'h009003);
    dl_addr = 25'h0000010;
    dl_data = 8'h11;
    dl_wr   = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    @(negedge clk_sys);
    dl_addr = 25'h0000012;
    dl_data = 8'h22;
    dl_wr   = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    chk("t4_overflow_set", 32'(dl_overflow), 32'h1);
    wait_idle("t4");
    chk("t4_overflow_held", 32'(dl_overflow), 32'h1);

    // cpu1 address moves while its read is in flight.
    push_rd(23'h000040); push_rd(23'h000030);
    push_q(CL_CPU1, 32'h0000A50A);
    push_q(CL_CPU1, 32'h0000A57A);
    cpu1_addr = 16'h0040;
    wait_toggle("t6");
    cpu1_addr = 16'h0030;
    wait_idle("t6");

    // Reset lands during a cpu2 read; the ack completes inside reset.
    lat = 8;
    push_rd(23'h007007);
    cpu2_addr = 16'h0007;
    wait_toggle("t5");
    repeat (2) @(negedge clk_sys);
    chk("t5_req_inflight", 32'(mem_req), 32'h1);
    chk("t5_ack_inflight", 32'(mem_ack), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (mem_ack) break;
    end
    repeat (3) @(negedge clk_sys);
    chk("t5_ack_done", 32'(mem_ack), 32'h1);
    chk("t5_req_resync", 32'(mem_req), 32'h1);
    chk("t5_cpu1_q", 32'(cpu1_q), 32'h0);
    chk("t5_cpu2_q", 32'(cpu2_q), 32'h0);
    chk("t5_sp_q", sp_q, 32'h0);
    chk("t5_overflow", 32'(dl_overflow), 32'h0);
    push_rd(23'h000030); push_rd(23'h007007); push_rd(23'h009002); push_rd(23'h009003);
    push_q(CL_CPU1, 32'h0000A57A);
    push_q(CL_CPU2, 32'h0000D54D);
    push_q(CL_SP,   32'h35493548);
    reset = 1'b0;
    wait_idle("t5");

    chk("end_txn_queue", 32'(exp_txn.size()), 32'h0);
    chk("end_q_queue", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
